// File: rtl/data_mem_responder.sv
// Data-memory responder: fixed-latency load/store engine over a byte-lane word RAM.
// Optional MEM_ACCESS_COUNT_EN adds completed load/store counters (rd_count, wr_count).
module data_mem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memenM,
    input  logic        memwriteM,
    input  logic [1:0]  sizeM,
    input  logic [31:0] addrM,
    input  logic [31:0] writedataM,
    input  logic        flushM,
    output logic [31:0] readdataM,
    output logic        memstallM,
    output logic        addr_err
`ifdef MEM_ACCESS_COUNT_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [3:0]              cnt_r;
    logic [DEPTH_LOG2-1:0]   idx_r;
    logic [1:0]              off_r;
    logic [1:0]              size_r;
    logic                    we_r;
    logic [31:0]             wdata_r;
    logic                    misalign_s;
    logic                    accept_s;
    logic                    access_s;
    logic [3:0]              be_s;
    logic [31:0]             lane_data_s;
    logic [31:0]             mem_r [DEPTH];
    logic                    unused_s;

    // Address bits above the word index alias onto the same word.
    assign unused_s   = ^addrM[31:DEPTH_LOG2+2];
    assign misalign_s = ((sizeM == 2'b01) && addrM[0]) ||
                        (sizeM[1] && (addrM[1:0] != 2'b00));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (memenM && !misalign_s) state_next_s = ST_BUSY;
                else                       state_next_s = ST_IDLE;
            end
            ST_BUSY: begin
                if (flushM)              state_next_s = ST_IDLE;
                else if (cnt_r == 4'd1)  state_next_s = ST_DONE;
                else                     state_next_s = ST_BUSY;
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs: stall is combinational so the accepting cycle already freezes the pipe
    always_comb begin
        accept_s  = 1'b0;
        access_s  = 1'b0;
        memstallM = 1'b0;
        case (state_r)
            ST_IDLE: begin
                accept_s  = memenM && !misalign_s;
                memstallM = memenM && !misalign_s;
            end
            ST_BUSY: begin
                access_s  = !flushM && (cnt_r == 4'd1);
                memstallM = 1'b1;
            end
            ST_DONE: memstallM = 1'b0;
            default: memstallM = 1'b0;
        endcase
    end

    // Request capture and wait counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r   <= 4'd0;
            idx_r   <= '0;
            off_r   <= 2'd0;
            size_r  <= 2'd0;
            we_r    <= 1'b0;
            wdata_r <= 32'd0;
        end else if (accept_s) begin
            cnt_r   <= 4'(LATENCY);
            idx_r   <= addrM[DEPTH_LOG2+1:2];
            off_r   <= addrM[1:0];
            size_r  <= sizeM;
            we_r    <= memwriteM;
            wdata_r <= writedataM;
        end else if ((state_r == ST_BUSY) && !flushM && (cnt_r != 4'd1)) begin
            cnt_r <= cnt_r - 4'd1;
        end
    end

    // Lane enables and replicated store data
    always_comb begin
        be_s        = 4'b1111;
        lane_data_s = wdata_r;
        case (size_r)
            2'b00: begin
                be_s        = 4'b0001 << off_r;
                lane_data_s = {4{wdata_r[7:0]}};
            end
            2'b01: begin
                be_s        = off_r[1] ? 4'b1100 : 4'b0011;
                lane_data_s = {2{wdata_r[15:0]}};
            end
            default: begin
                be_s        = 4'b1111;
                lane_data_s = wdata_r;
            end
        endcase
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (access_s && we_r) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) mem_r[idx_r][8*b +: 8] <= lane_data_s[8*b +: 8];
            end
        end
    end

    // Load data register and misalignment pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            readdataM <= 32'd0;
            addr_err  <= 1'b0;
        end else begin
            if (access_s && !we_r) readdataM <= mem_r[idx_r];
            addr_err <= (state_r == ST_IDLE) && memenM && misalign_s;
        end
    end

`ifdef MEM_ACCESS_COUNT_EN
    // Completed-access counters, free-running with wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_count <= 32'd0;
            wr_count <= 32'd0;
        end else if (access_s) begin
            if (we_r) wr_count <= wr_count + 32'd1;
            else      rd_count <= rd_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a word-array reference model.
// A second instance with LATENCY=1 covers held back-to-back requests and address aliasing.
module tb_data_mem_responder;

    localparam int DL2   = 6;
    localparam int LAT   = 2;
    localparam int WORDS = 1 << DL2;

    logic        clk = 1'b0;
    logic        rst;
    logic        memen, memen2, memwrite, flush;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [31:0] rdata, rdata2;
    logic        stall, stall2, aerr, aerr2;
`ifdef MEM_ACCESS_COUNT_EN
    logic [31:0] rdc, wrc, rdc2, wrc2;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [31:0] ref_mem [WORDS];
    logic [31:0] ref_rd;
    int unsigned ref_rdc, ref_wrc;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_LOG2(DL2), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .memenM(memen), .memwriteM(memwrite), .sizeM(size),
        .addrM(addr), .writedataM(wdata), .flushM(flush), .readdataM(rdata),
        .memstallM(stall), .addr_err(aerr)
`ifdef MEM_ACCESS_COUNT_EN
        , .rd_count(rdc), .wr_count(wrc)
`endif
    );

    data_mem_responder #(.DEPTH_LOG2(DL2), .LATENCY(1)) dut2 (
        .clk(clk), .rst(rst), .memenM(memen2), .memwriteM(memwrite), .sizeM(size),
        .addrM(addr), .writedataM(wdata), .flushM(flush), .readdataM(rdata2),
        .memstallM(stall2), .addr_err(aerr2)
`ifdef MEM_ACCESS_COUNT_EN
        , .rd_count(rdc2), .wr_count(wrc2)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Little-endian lane update: the store's low bytes are repeated across its aligned span.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] sz,
                                          input logic [31:0] a, input logic [31:0] d);
        int nb, base;
        logic [31:0] v;
        nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        base = (int'(a % 4) / nb) * nb;
        v    = old;
        for (int b = 0; b < 4; b++)
            if (b >= base && b < base + nb) v[8*b +: 8] = 8'(d >> (8 * (b % nb)));
        return v;
    endfunction

    function automatic bit is_misaligned(input logic [1:0] sz, input logic [31:0] a);
        return ((sz == 2'd1) && (a % 2 != 0)) || ((sz >= 2'd2) && (a % 4 != 0));
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            memen = 1'b0;
            flush = 1'b0;
            #1;
            check_val("idle_stall", 32'(stall), 32'd0);
            check_val("idle_aerr", 32'(aerr), 32'd0);
        end
    endtask

    task automatic access(input logic we, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] d, input int flush_at);
        int idx;
        idx = int'((a / 4) % WORDS);
        @(negedge clk);
        memen = 1'b1; memwrite = we; size = sz; addr = a; wdata = d; flush = 1'b0;
        #1;
        if (is_misaligned(sz, a)) begin
            check_val("mis_stall", 32'(stall), 32'd0);
            @(negedge clk); memen = 1'b0; #1;
            check_val("mis_aerr_hi", 32'(aerr), 32'd1);
            check_val("mis_stall2", 32'(stall), 32'd0);
            @(negedge clk); #1;
            check_val("mis_aerr_lo", 32'(aerr), 32'd0);
            check_val("mis_rd_hold", rdata, ref_rd);
            return;
        end
        check_val("acc_stall", 32'(stall), 32'd1);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            memen = 1'b0;
            flush = (k == flush_at);
            #1;
            check_val("busy_stall", 32'(stall), 32'd1);
            if (k == flush_at) begin
                @(negedge clk); flush = 1'b0; #1;
                check_val("flush_stall", 32'(stall), 32'd0);
                check_val("flush_rd_hold", rdata, ref_rd);
                return;
            end
        end
        @(negedge clk);
        memen = 1'($urandom % 2);
        flush = 1'($urandom % 2);
        #1;
        check_val("done_stall", 32'(stall), 32'd0);
        if (we) begin
            ref_mem[idx] = merge(ref_mem[idx], sz, a, d);
            ref_wrc++;
        end else begin
            ref_rd = ref_mem[idx];
            ref_rdc++;
        end
        check_val("rdata", rdata, ref_rd);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] patt [4];
        rst = 1'b0; memen = 1'b0; memen2 = 1'b0; memwrite = 1'b0; flush = 1'b0;
        size = 2'd0; addr = 32'd0; wdata = 32'd0;
        ref_rd = 32'd0; ref_rdc = 0; ref_wrc = 0;
        #1;
        check_val("rst_rdata", rdata, 32'd0);
        check_val("rst_stall", 32'(stall), 32'd0);
        check_val("rst_aerr", 32'(aerr), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < WORDS; i++) access(1'b1, 2'd2, 32'(4 * i), $urandom, -1);

        access(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, -1);
        access(1'b0, 2'd2, 32'h10, 32'd0, -1);
        check_val("word_load", rdata, 32'hDEADBEEF);

        access(1'b1, 2'd2, 32'h20, 32'd0, -1);
        access(1'b1, 2'd0, 32'h21, 32'h000000AB, -1);
        access(1'b1, 2'd1, 32'h22, 32'h00001234, -1);
        access(1'b0, 2'd2, 32'h20, 32'd0, -1);
        check_val("lane_load", rdata, 32'h1234AB00);

        access(1'b0, 2'd2, 32'h06, 32'd0, -1);
        check_val("mis_keep", rdata, 32'h1234AB00);

        access(1'b1, 2'd2, 32'h30, 32'h00000055, 1);
        access(1'b0, 2'd2, 32'h30, 32'd0, -1);

        for (int i = 0; i < 200; i++) begin
            sz = 2'($urandom % 4);
            a  = $urandom % 1024;
            access(1'($urandom % 2), sz, a, $urandom,
                   ($urandom % 8 == 0) ? int'(1 + $urandom % LAT) : -1);
            if ($urandom % 4 == 0) idle(int'(1 + $urandom % 2));
        end
        for (int i = 0; i < WORDS; i++) access(1'b0, 2'd2, 32'(4 * i + 1024 * (i % 3)), 32'd0, -1);

`ifdef MEM_ACCESS_COUNT_EN
        idle(1);
        check_val("rd_count", rdc, 32'(ref_rdc));
        check_val("wr_count", wrc, 32'(ref_wrc));
`endif

        // Reset in the first busy cycle of a store
        @(negedge clk);
        memen = 1'b1; memwrite = 1'b1; size = 2'd2; addr = 32'h10; wdata = 32'hCAFEF00D;
        @(negedge clk);
        memen = 1'b0; rst = 1'b0; #1;
        check_val("rstmid_stall", 32'(stall), 32'd0);
        check_val("rstmid_rdata", rdata, 32'd0);
        ref_rd = 32'd0; ref_rdc = 0; ref_wrc = 0;
        @(negedge clk); rst = 1'b1;
        access(1'b0, 2'd2, 32'h10, 32'd0, -1);
        access(1'b0, 2'd2, 32'h20, 32'd0, -1);
`ifdef MEM_ACCESS_COUNT_EN
        idle(1);
        check_val("rd_count_post", rdc, 32'(ref_rdc));
        check_val("wr_count_post", wrc, 32'(ref_wrc));
`endif

        // LATENCY=1 instance: held request, stores then aliased loads
        patt[0] = 32'h0;  patt[1] = 32'h0;  patt[2] = $urandom; patt[3] = $urandom;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            memen2 = 1'b1; size = 2'd2;
            case (j)
                0:       begin memwrite = 1'b1; addr = 32'h044; wdata = patt[2]; end
                1:       begin memwrite = 1'b1; addr = 32'h148; wdata = patt[3]; end
                2:       begin memwrite = 1'b0; addr = 32'h244; end
                3:       begin memwrite = 1'b0; addr = 32'h048; end
                default: begin memwrite = 1'b0; addr = 32'h344; end
            endcase
            #1;
            check_val("b2b_stall0", 32'(stall2), 32'd1);
            @(negedge clk); #1;
            check_val("b2b_stall1", 32'(stall2), 32'd1);
            @(negedge clk); #1;
            check_val("b2b_done", 32'(stall2), 32'd0);
            if (j >= 2) check_val("b2b_alias", rdata2, (j == 3) ? patt[3] : patt[2]);
        end
        @(negedge clk);
        memen2 = 1'b0;
        #1;
`ifdef MEM_ACCESS_COUNT_EN
        check_val("b2b_rd_count", rdc2, 32'd3);
        check_val("b2b_wr_count", wrc2, 32'd2);
`endif
        check_val("b2b_idle", 32'(stall2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
